// File: rtl/nwr_req_sched_if.sv
// Header and response channels between the request scheduler and the NWRITE framer.
// The scheduler holds the master modport; the framer/response side holds the slave modport.
interface nwr_req_sched_if #(
   parameter int ADDR_WIDTH = 34,
   parameter int TID_WIDTH  = 8
);
   logic                  hdr_valid_out;
   logic                  hdr_ready_in;
   logic [TID_WIDTH-1:0]  hdr_tid_out;
   logic [ADDR_WIDTH-1:0] hdr_addr_out;
   logic [7:0]            hdr_size_out;
   logic [15:0]           hdr_dest_out;
   logic                  resp_valid_in;
   logic [3:0]            resp_status_in;
   logic                  resp_ready_out;

   modport master (
      output hdr_valid_out, hdr_tid_out, hdr_addr_out, hdr_size_out, hdr_dest_out,
      output resp_ready_out,
      input  hdr_ready_in, resp_valid_in, resp_status_in
   );

   modport slave (
      input  hdr_valid_out, hdr_tid_out, hdr_addr_out, hdr_size_out, hdr_dest_out,
      input  resp_ready_out,
      output hdr_ready_in, resp_valid_in, resp_status_in
   );
endinterface

// File: rtl/nwr_req_sched.sv
// Splits one user message into 256-byte NWRITE packets, issues a header per packet,
// gates the reader's fetch and tracks outstanding responses against a credit limit.
module nwr_req_sched #(
   parameter int ADDR_WIDTH      = 34,
   parameter int MAX_OUTSTANDING = 8,
   parameter int TID_WIDTH       = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start_in,
   input  logic [ADDR_WIDTH-1:0] base_addr_in,
   input  logic [15:0]           dest_id_in,
   output logic                  busy_out,
   output logic                  done_out,
   output logic                  err_out,
   output logic                  fetch_data_out,
   input  logic                  pack_tlast_in,
   input  logic                  msg_tlast_in,
   input  logic                  tvalid_in,
   input  logic                  tready_in,
   input  logic [7:0]            data_len_in,
   nwr_req_sched_if.master       bus
);

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      DATA,
      CREDIT,
      DRAIN
   } state_t;

   localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);

   state_t                 state;
   logic [ADDR_WIDTH-1:0]  base_q;
   logic [ADDR_WIDTH-9:0]  pack_idx;
   logic [15:0]            dest_q;
   logic [TID_WIDTH-1:0]   tid;
   logic [7:0]             outstanding;
   logic [7:0]             outstanding_nxt;
   logic                   sticky_err;
   logic                   sticky_err_nxt;
   logic                   hdr_valid_q;
   logic                   fetch_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   err_q;
   logic                   resp_ready_q;
   logic                   hdr_accept;
   logic                   resp_fire;
   logic                   pkt_end;
   logic                   credit_ok;

   // Credit decisions look at the post-response count so a response frees a slot in the same cycle.
   always_comb begin
      hdr_accept      = hdr_valid_q & bus.hdr_ready_in;
      resp_fire       = bus.resp_valid_in & resp_ready_q;
      pkt_end         = (state == DATA) & tvalid_in & tready_in & pack_tlast_in;
      outstanding_nxt = outstanding;
      if (hdr_accept && !resp_fire) begin
         outstanding_nxt = outstanding + 8'd1;
      end else if (!hdr_accept && resp_fire && (outstanding != 8'd0)) begin
         outstanding_nxt = outstanding - 8'd1;
      end
      sticky_err_nxt = sticky_err |
                       (resp_fire & ((bus.resp_status_in != 4'd0) | (outstanding == 8'd0)));
      credit_ok      = outstanding_nxt < MAX_OUT;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         base_q       <= '0;
         pack_idx     <= '0;
         dest_q       <= '0;
         tid          <= '0;
         outstanding  <= '0;
         sticky_err   <= 1'b0;
         hdr_valid_q  <= 1'b0;
         fetch_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         resp_ready_q <= 1'b0;
      end else begin
         resp_ready_q <= 1'b1;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         outstanding  <= outstanding_nxt;
         sticky_err   <= sticky_err_nxt;
         if (hdr_accept) begin
            tid      <= tid + TID_WIDTH'(1);
            pack_idx <= pack_idx + (ADDR_WIDTH-8)'(1);
         end
         case (state)
            IDLE: begin
               if (start_in) begin
                  base_q      <= base_addr_in;
                  dest_q      <= dest_id_in;
                  pack_idx    <= '0;
                  sticky_err  <= 1'b0;
                  busy_q      <= 1'b1;
                  hdr_valid_q <= 1'b1;
                  state       <= HDR;
               end
            end
            HDR: begin
               if (hdr_accept) begin
                  hdr_valid_q <= 1'b0;
                  fetch_q     <= 1'b1;
                  state       <= DATA;
               end
            end
            DATA: begin
               if (pkt_end) begin
                  fetch_q <= 1'b0;
                  if (msg_tlast_in) begin
                     state <= DRAIN;
                  end else if (credit_ok) begin
                     hdr_valid_q <= 1'b1;
                     state       <= HDR;
                  end else begin
                     state <= CREDIT;
                  end
               end
            end
            CREDIT: begin
               if (credit_ok) begin
                  hdr_valid_q <= 1'b1;
                  state       <= HDR;
               end
            end
            DRAIN: begin
               if (outstanding_nxt == 8'd0) begin
                  done_q <= 1'b1;
                  err_q  <= sticky_err_nxt;
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Packet address is derived from the index so it wraps naturally at the address width.
   assign bus.hdr_addr_out   = base_q + {pack_idx, 8'h00};
   assign bus.hdr_size_out   = hdr_valid_q ? data_len_in : 8'h00;
   assign bus.hdr_valid_out  = hdr_valid_q;
   assign bus.hdr_tid_out    = tid;
   assign bus.hdr_dest_out   = dest_q;
   assign bus.resp_ready_out = resp_ready_q;
   assign busy_out           = busy_q;
   assign done_out           = done_q;
   assign err_out            = err_q;
   assign fetch_data_out     = fetch_q;

endmodule

// File: tb/tb_nwr_req_sched.sv
// Directed bench for nwr_req_sched with a credit limit of 2; inputs change and outputs
// are sampled on the falling edge.
module tb_nwr_req_sched;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start_in;
   logic [33:0] base_addr_in;
   logic [15:0] dest_id_in;
   logic        busy_out;
   logic        done_out;
   logic        err_out;
   logic        fetch_data_out;
   logic        pack_tlast_in;
   logic        msg_tlast_in;
   logic        tvalid_in;
   logic        tready_in;
   logic [7:0]  data_len_in;

   int vec_count  = 0;
   int miss_count = 0;
   int hdr_count  = 0;
   int hdr_base;

   nwr_req_sched_if #(.ADDR_WIDTH(34), .TID_WIDTH(8)) bus ();

   nwr_req_sched #(
      .ADDR_WIDTH(34),
      .MAX_OUTSTANDING(2),
      .TID_WIDTH(8)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .start_in(start_in),
      .base_addr_in(base_addr_in),
      .dest_id_in(dest_id_in),
      .busy_out(busy_out),
      .done_out(done_out),
      .err_out(err_out),
      .fetch_data_out(fetch_data_out),
      .pack_tlast_in(pack_tlast_in),
      .msg_tlast_in(msg_tlast_in),
      .tvalid_in(tvalid_in),
      .tready_in(tready_in),
      .data_len_in(data_len_in),
      .bus(bus.master)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset_n && bus.hdr_valid_out && bus.hdr_ready_in) hdr_count <= hdr_count + 1;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic tv, input logic tr, input logic pl, input logic ml);
      tvalid_in     = tv;
      tready_in     = tr;
      pack_tlast_in = pl;
      msg_tlast_in  = ml;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec_count++;
      assert (obs === exp) else begin
         miss_count++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One-packet message with hdr_ready high and a DONE response right after the packet.
   task automatic run_msg(input logic [33:0] base, input logic [7:0] len, input logic [7:0] exp_tid);
      base_addr_in = base;
      data_len_in  = len;
      start_in     = 1'b1;
      @(negedge clk);
      start_in = 1'b0;
      checkOutput("msg_tid", {56'd0, bus.hdr_tid_out}, {56'd0, exp_tid});
      checkOutput("msg_addr", {30'd0, bus.hdr_addr_out}, {30'd0, base});
      @(negedge clk);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      bus.resp_valid_in = 1'b1;
      @(negedge clk);
      bus.resp_valid_in = 1'b0;
      checkOutput("msg_done", {63'd0, done_out}, 64'd1);
      checkOutput("msg_err", {63'd0, err_out}, 64'd0);
   endtask

   initial begin
      reset_n            = 1'b0;
      start_in           = 1'b0;
      base_addr_in       = '0;
      dest_id_in         = '0;
      data_len_in        = 8'hAA;
      bus.hdr_ready_in   = 1'b1;
      bus.resp_valid_in  = 1'b0;
      bus.resp_status_in = 4'd0;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (3) @(negedge clk);

      // Reset state
      checkOutput("rst_busy", {63'd0, busy_out}, 64'd0);
      checkOutput("rst_hdr_valid", {63'd0, bus.hdr_valid_out}, 64'd0);
      checkOutput("rst_fetch", {63'd0, fetch_data_out}, 64'd0);
      checkOutput("rst_done", {63'd0, done_out}, 64'd0);
      checkOutput("rst_err", {63'd0, err_out}, 64'd0);
      checkOutput("rst_resp_ready", {63'd0, bus.resp_ready_out}, 64'd0);
      checkOutput("rst_tid", {56'd0, bus.hdr_tid_out}, 64'd0);
      checkOutput("rst_addr", {30'd0, bus.hdr_addr_out}, 64'd0);
      checkOutput("rst_size", {56'd0, bus.hdr_size_out}, 64'd0);
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_resp_ready", {63'd0, bus.resp_ready_out}, 64'd1);

      // Single 255-byte packet, DONE response a few cycles after the packet
      data_len_in  = 8'hFF;
      base_addr_in = 34'h1_0000_0000;
      dest_id_in   = 16'h1234;
      hdr_base     = hdr_count;
      start_in     = 1'b1;
      @(negedge clk);
      start_in = 1'b0;
      checkOutput("t1_busy", {63'd0, busy_out}, 64'd1);
      checkOutput("t1_hdr_valid", {63'd0, bus.hdr_valid_out}, 64'd1);
      checkOutput("t1_addr", {30'd0, bus.hdr_addr_out}, 64'h1_0000_0000);
      checkOutput("t1_size", {56'd0, bus.hdr_size_out}, 64'hFF);
      checkOutput("t1_tid", {56'd0, bus.hdr_tid_out}, 64'd0);
      checkOutput("t1_dest", {48'd0, bus.hdr_dest_out}, 64'h1234);
      checkOutput("t1_fetch_pre", {63'd0, fetch_data_out}, 64'd0);
      @(negedge clk);
      checkOutput("t1_fetch", {63'd0, fetch_data_out}, 64'd1);
      checkOutput("t1_hdr_drop", {63'd0, bus.hdr_valid_out}, 64'd0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("t1_fetch_off", {63'd0, fetch_data_out}, 64'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("t1_no_done", {63'd0, done_out}, 64'd0);
      end
      bus.resp_valid_in = 1'b1;
      @(negedge clk);
      bus.resp_valid_in = 1'b0;
      checkOutput("t1_done", {63'd0, done_out}, 64'd1);
      checkOutput("t1_err", {63'd0, err_out}, 64'd0);
      checkOutput("t1_busy_off", {63'd0, busy_out}, 64'd0);
      checkOutput("t1_hdr_count", 64'(hdr_count - hdr_base), 64'd1);
      @(negedge clk);
      checkOutput("t1_done_pulse", {63'd0, done_out}, 64'd0);

      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Four packets with credit limit 2 and withheld responses
      base_addr_in = 34'h0_0000_1000;
      start_in     = 1'b1;
      @(negedge clk);
      start_in = 1'b0;
      checkOutput("t2_addr0", {30'd0, bus.hdr_addr_out}, 64'h1000);
      checkOutput("t2_tid0", {56'd0, bus.hdr_tid_out}, 64'd0);
      @(negedge clk);
      checkOutput("t2_fetch0", {63'd0, fetch_data_out}, 64'd1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("t2_hdr1_valid", {63'd0, bus.hdr_valid_out}, 64'd1);
      checkOutput("t2_addr1", {30'd0, bus.hdr_addr_out}, 64'h1100);
      checkOutput("t2_tid1", {56'd0, bus.hdr_tid_out}, 64'd1);
      checkOutput("t2_fetch_gap", {63'd0, fetch_data_out}, 64'd0);
      @(negedge clk);
      checkOutput("t2_fetch1", {63'd0, fetch_data_out}, 64'd1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("t2_credit_hdr", {63'd0, bus.hdr_valid_out}, 64'd0);
      checkOutput("t2_credit_fetch", {63'd0, fetch_data_out}, 64'd0);
      checkOutput("t2_outstanding2", {56'd0, dut.outstanding}, 64'd2);
      repeat (3) @(negedge clk);
      checkOutput("t2_credit_hold", {63'd0, bus.hdr_valid_out}, 64'd0);
      bus.resp_valid_in = 1'b1;
      @(negedge clk);
      bus.resp_valid_in = 1'b0;
      checkOutput("t2_hdr2_valid", {63'd0, bus.hdr_valid_out}, 64'd1);
      checkOutput("t2_addr2", {30'd0, bus.hdr_addr_out}, 64'h1200);
      checkOutput("t2_tid2", {56'd0, bus.hdr_tid_out}, 64'd2);
      checkOutput("t2_outstanding1", {56'd0, dut.outstanding}, 64'd1);
      @(negedge clk);
      checkOutput("t2_fetch2", {63'd0, fetch_data_out}, 64'd1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("t2_credit2_hdr", {63'd0, bus.hdr_valid_out}, 64'd0);
      @(negedge clk);
      checkOutput("t2_credit2_hold", {63'd0, bus.hdr_valid_out}, 64'd0);
      bus.resp_valid_in = 1'b1;
      @(negedge clk);
      bus.resp_valid_in = 1'b0;
      checkOutput("t2_hdr3_valid", {63'd0, bus.hdr_valid_out}, 64'd1);
      checkOutput("t2_addr3", {30'd0, bus.hdr_addr_out}, 64'h1300);
      checkOutput("t2_tid3", {56'd0, bus.hdr_tid_out}, 64'd3);
      @(negedge clk);
      checkOutput("t2_fetch3", {63'd0, fetch_data_out}, 64'd1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("t2_drain_hdr", {63'd0, bus.hdr_valid_out}, 64'd0);
      checkOutput("t2_drain_outstanding", {56'd0, dut.outstanding}, 64'd2);
      bus.resp_valid_in = 1'b1;
      @(negedge clk);
      checkOutput("t2_drain_wait", {63'd0, done_out}, 64'd0);
      @(negedge clk);
      bus.resp_valid_in = 1'b0;
      checkOutput("t2_done", {63'd0, done_out}, 64'd1);
      checkOutput("t2_err", {63'd0, err_out}, 64'd0);
      checkOutput("t2_busy_off", {63'd0, busy_out}, 64'd0);

      // Address wrap, hdr_ready stall, same-cycle accept+response, error response
      base_addr_in = 34'h3_FFFF_FF00;
      data_len_in  = 8'h7F;
      start_in     = 1'b1;
      @(negedge clk);
      start_in = 1'b0;
      checkOutput("t3_addr0", {30'd0, bus.hdr_addr_out}, 64'h3_FFFF_FF00);
      checkOutput("t3_tid0", {56'd0, bus.hdr_tid_out}, 64'd4);
      @(negedge clk);
      checkOutput("t3_outstanding1", {56'd0, dut.outstanding}, 64'd1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      bus.hdr_ready_in = 1'b0;
      checkOutput("t3_wrap_addr", {30'd0, bus.hdr_addr_out}, 64'd0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("t3_stall_valid", {63'd0, bus.hdr_valid_out}, 64'd1);
         checkOutput("t3_stall_addr", {30'd0, bus.hdr_addr_out}, 64'd0);
         checkOutput("t3_stall_tid", {56'd0, bus.hdr_tid_out}, 64'd5);
         checkOutput("t3_stall_size", {56'd0, bus.hdr_size_out}, 64'h7F);
         checkOutput("t3_stall_fetch", {63'd0, fetch_data_out}, 64'd0);
         checkOutput("t3_stall_outstanding", {56'd0, dut.outstanding}, 64'd1);
      end
      bus.hdr_ready_in  = 1'b1;
      bus.resp_valid_in = 1'b1;
      @(negedge clk);
      bus.resp_valid_in = 1'b0;
      checkOutput("t3_same_cycle_outstanding", {56'd0, dut.outstanding}, 64'd1);
      checkOutput("t3_fetch", {63'd0, fetch_data_out}, 64'd1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      bus.resp_valid_in  = 1'b1;
      bus.resp_status_in = 4'd7;
      @(negedge clk);
      bus.resp_valid_in  = 1'b0;
      bus.resp_status_in = 4'd0;
      checkOutput("t3_done", {63'd0, done_out}, 64'd1);
      checkOutput("t3_err", {63'd0, err_out}, 64'd1);

      // Unexpected response before start is forgotten; after start it poisons the message
      bus.resp_valid_in = 1'b1;
      @(negedge clk);
      bus.resp_valid_in = 1'b0;
      run_msg(34'h0_0000_2000, 8'h10, 8'd6);
      base_addr_in = 34'h0_0000_3000;
      start_in     = 1'b1;
      @(negedge clk);
      start_in          = 1'b0;
      bus.hdr_ready_in  = 1'b0;
      bus.resp_valid_in = 1'b1;
      @(negedge clk);
      bus.resp_valid_in = 1'b0;
      bus.hdr_ready_in  = 1'b1;
      checkOutput("t4_unexp_outstanding", {56'd0, dut.outstanding}, 64'd0);
      checkOutput("t4_tid", {56'd0, bus.hdr_tid_out}, 64'd7);
      @(negedge clk);
      checkOutput("t4_fetch", {63'd0, fetch_data_out}, 64'd1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      bus.resp_valid_in = 1'b1;
      @(negedge clk);
      bus.resp_valid_in = 1'b0;
      checkOutput("t4_done", {63'd0, done_out}, 64'd1);
      checkOutput("t4_err", {63'd0, err_out}, 64'd1);

      // Reset mid-DATA
      base_addr_in = 34'h0_0000_4000;
      dest_id_in   = 16'hBEEF;
      start_in     = 1'b1;
      @(negedge clk);
      start_in = 1'b0;
      @(negedge clk);
      checkOutput("t5_in_data", {63'd0, fetch_data_out}, 64'd1);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("t5_rst_fetch", {63'd0, fetch_data_out}, 64'd0);
      checkOutput("t5_rst_busy", {63'd0, busy_out}, 64'd0);
      checkOutput("t5_rst_hdr_valid", {63'd0, bus.hdr_valid_out}, 64'd0);
      checkOutput("t5_rst_resp_ready", {63'd0, bus.resp_ready_out}, 64'd0);
      checkOutput("t5_rst_tid", {56'd0, bus.hdr_tid_out}, 64'd0);
      checkOutput("t5_rst_addr", {30'd0, bus.hdr_addr_out}, 64'd0);
      checkOutput("t5_rst_dest", {48'd0, bus.hdr_dest_out}, 64'd0);
      checkOutput("t5_rst_outstanding", {56'd0, dut.outstanding}, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run_msg(34'h0_0000_5000, 8'h20, 8'd0);

      // TID rollover: tids 1..255 then 0
      for (int i = 1; i <= 256; i++) begin
         run_msg(34'h0_0000_6000, 8'h08, 8'(i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule
